// File: rtl/fme_pkg.sv
// Shared FME definitions: FSM states, candidate index width and default SAD width
// used by the integer-ME, half-pel and quarter-pel stages.
package fme_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CAND_W    = 4;
  localparam int INT_POS   = 0;
  localparam int SAD_W_DEF = 16;

endpackage

// File: rtl/sad_acc.sv
// Absolute-difference register stage feeding a saturating SAD accumulator.
// A beat flagged 'first' restarts the sum, so candidates abut without a bubble.
module sad_acc #(
  parameter int PIX_W = 8,
  parameter int SAD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  input  logic             first,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [SAD_W-1:0] acc
);

  logic [PIX_W:0] diff_ab;
  logic [PIX_W:0] diff_ba;
  logic [PIX_W:0] ad;
  logic           s1_vld;
  logic           s1_first;
  logic [SAD_W:0] sum;

  assign diff_ab = {1'b0, a} - {1'b0, b};
  assign diff_ba = {1'b0, b} - {1'b0, a};
  assign sum     = {1'b0, acc} + (SAD_W+1)'(ad);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ad       <= '0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      acc      <= '0;
    end else begin
      s1_vld   <= in_vld;
      s1_first <= first;
      ad       <= (a >= b) ? diff_ab : diff_ba;
      if (s1_vld) begin
        if (s1_first)
          acc <= SAD_W'(ad);
        else
          acc <= sum[SAD_W] ? '1 : sum[SAD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/half_sad_sel.sv
// Half-pel candidate selector: accumulates SAD for each of NUM_CAND candidates
// and keeps the cheapest position, integer position included.
module half_sad_sel
  import fme_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int BLK_PIX  = 16,
  parameter int NUM_CAND = 8,
  parameter int SAD_W    = SAD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SAD_W-1:0]  int_sad,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  cand_pix,
  input  logic [PIX_W-1:0]  cur_pix,
  output logic [CAND_W-1:0] cand_req,
  output logic              busy,
  output logic              done,
  output logic [CAND_W-1:0] best_cand,
  output logic [SAD_W-1:0]  best_sad
);

  localparam int PC_W = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;

  state_t            state;
  logic [PC_W-1:0]   pix_cnt;
  logic [CAND_W-1:0] cand_cnt;
  logic              beat;
  logic              pix_last;
  logic              clr;
  logic [SAD_W-1:0]  acc;
  // [0]: last beat of a candidate in the |a-b| stage; [1]: its sum now sits in acc
  logic [1:0]        last_pipe;
  logic [CAND_W-1:0] s1_cand;
  logic [CAND_W-1:0] close_cand;

  assign beat     = (state == ACCUM) && pix_valid;
  assign pix_last = (pix_cnt == PC_W'(BLK_PIX - 1));
  assign clr      = (state == IDLE) && start;

  sad_acc #(
    .PIX_W (PIX_W),
    .SAD_W (SAD_W)
  ) u_sad_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .in_vld (beat),
    .first  (beat && (pix_cnt == '0)),
    .a      (cand_pix),
    .b      (cur_pix),
    .acc    (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      cand_cnt   <= '0;
      cand_req   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_cand  <= '0;
      best_sad   <= '0;
      last_pipe  <= '0;
      s1_cand    <= '0;
      close_cand <= '0;
    end else begin
      last_pipe[0] <= beat && pix_last;
      last_pipe[1] <= last_pipe[0];
      s1_cand      <= cand_cnt;
      close_cand   <= s1_cand;

      // Strict less-than: ties keep the earlier (lower-index) position.
      if (last_pipe[1] && (acc < best_sad)) begin
        best_sad  <= acc;
        best_cand <= close_cand;
      end

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            best_sad  <= int_sad;
            best_cand <= CAND_W'(INT_POS);
            pix_cnt   <= '0;
            cand_cnt  <= CAND_W'(1);
            cand_req  <= CAND_W'(1);
            busy      <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (pix_valid) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_last) begin
              if (cand_cnt == CAND_W'(NUM_CAND)) begin
                cand_req <= '0;
                state    <= FLUSH;
              end else begin
                cand_cnt <= cand_cnt + 1'b1;
                cand_req <= cand_cnt + 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          if (last_pipe[1] && (close_cand == CAND_W'(NUM_CAND))) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_half_sad_sel.sv
// Directed vector bench for half_sad_sel: table of searches plus reset/protocol sequences.
module tb_half_sad_sel;

  localparam int PIX_W    = 8;
  localparam int BLK_PIX  = 16;
  localparam int NUM_CAND = 8;
  localparam int SAD_W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [SAD_W-1:0]  int_sad;
  logic              pix_valid;
  logic [PIX_W-1:0]  cand_pix;
  logic [PIX_W-1:0]  cur_pix;
  logic [3:0]        cand_req;
  logic              busy;
  logic              done;
  logic [3:0]        best_cand;
  logic [SAD_W-1:0]  best_sad;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [15:0]     isad;
    logic [7:0][7:0] cp;
    logic [7:0][7:0] up;
    bit              bubbles;
    bit              noise;
    int              exp_cand;
    int              exp_sad;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  half_sad_sel #(
    .PIX_W    (PIX_W),
    .BLK_PIX  (BLK_PIX),
    .NUM_CAND (NUM_CAND),
    .SAD_W    (SAD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .int_sad   (int_sad),
    .pix_valid (pix_valid),
    .cand_pix  (cand_pix),
    .cur_pix   (cur_pix),
    .cand_req  (cand_req),
    .busy      (busy),
    .done      (done),
    .best_cand (best_cand),
    .best_sad  (best_sad)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-candidate |diff| d; odd candidates sit above cur, even below, to use both subtract paths.
  function automatic vec_t mk(input int isad, input int d[8], input int ec, input int es);
    vec_t v;
    v.isad = 16'(isad);
    for (int c = 0; c < 8; c++) begin
      v.up[c] = 8'd100;
      v.cp[c] = (c % 2 == 0) ? 8'(100 + d[c]) : 8'(100 - d[c]);
    end
    v.bubbles  = 1'b0;
    v.noise    = 1'b0;
    v.exp_cand = ec;
    v.exp_sad  = es;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int first_done;
    int dc0;
    string tag;
    tag = $sformatf("v%0d", id);
    @(negedge clk);
    start = 1'b1; int_sad = v.isad;
    pix_valid = 1'b1; cand_pix = 8'd0; cur_pix = 8'd255;   // must be dropped
    dc0 = done_cnt;
    for (int c = 0; c < NUM_CAND; c++) begin
      for (int p = 0; p < BLK_PIX; p++) begin
        @(negedge clk);
        start = 1'b0;
        if (v.bubbles) begin
          pix_valid = 1'b0; cand_pix = 8'd7; cur_pix = 8'd200;
          if (p == 0 || p == 15) chk({tag, " cand_req_bubble"}, cand_req, c + 1);
          @(negedge clk);
        end
        start = v.noise && (p == 7);
        int_sad = 16'd1;
        pix_valid = 1'b1; cand_pix = v.cp[c]; cur_pix = v.up[c];
        if (p == 0 || p == 15 || v.bubbles) chk({tag, " cand_req"}, cand_req, c + 1);
        if (p == 0) chk({tag, " busy"}, busy, 1);
      end
    end
    first_done = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      pix_valid = k[0]; cand_pix = 8'd0; cur_pix = 8'd255;
      if (done === 1'b1 && first_done == 0) begin
        first_done = k;
        chk({tag, " best_cand"}, best_cand, v.exp_cand);
        chk({tag, " best_sad"}, best_sad, v.exp_sad);
        chk({tag, " busy_at_done"}, busy, 0);
      end
    end
    pix_valid = 1'b0;
    chk({tag, " done_latency"}, first_done, 3);
    chk({tag, " done_count"}, done_cnt - dc0, 1);
    chk({tag, " hold_cand"}, best_cand, v.exp_cand);
    chk({tag, " hold_sad"}, best_sad, v.exp_sad);
  endtask

  initial begin
    int d[8];
    int dc0;
    rst = 1'b1; start = 1'b0; int_sad = '0; pix_valid = 1'b0; cand_pix = '0; cur_pix = '0;

    d = '{1, 1, 1, 1, 1, 1, 1, 1};
    vecs[0] = mk(10, d, 0, 10);
    d = '{3, 3, 3, 3, 0, 3, 3, 3};
    vecs[1] = mk(100, d, 5, 0);
    vecs[1].noise = 1'b1;
    d = '{4, 4, 2, 4, 4, 2, 4, 4};
    vecs[2] = mk(200, d, 3, 32);
    d = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = mk(16'hFFFF, d, 1, 4080);
    for (int c = 0; c < 8; c++) begin vecs[3].cp[c] = 8'd255; vecs[3].up[c] = 8'd0; end
    vecs[3].bubbles = 1'b1;
    d = '{5, 5, 5, 5, 5, 5, 5, 1};
    vecs[4] = mk(50, d, 8, 16);
    d = '{2, 2, 2, 2, 2, 2, 2, 2};
    vecs[5] = mk(32, d, 0, 32);
    d = '{8, 7, 6, 5, 4, 3, 2, 1};
    vecs[6] = mk(300, d, 8, 16);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset cand_req", cand_req, 0);
    chk("reset done", done, 0);
    chk("reset best_cand", best_cand, 0);
    chk("reset best_sad", best_sad, 0);

    // Beats while idle must not disturb anything.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pix_valid = 1'b1; cand_pix = 8'd200; cur_pix = 8'd0;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    chk("idle beats busy", busy, 0);
    chk("idle beats cand_req", cand_req, 0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a search aborts it silently.
    @(negedge clk);
    start = 1'b1; int_sad = 16'd77; pix_valid = 1'b0;
    dc0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0; pix_valid = 1'b1; cand_pix = 8'd11; cur_pix = 8'd10;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst cand_req", cand_req, 0);
    chk("midrst best_sad", best_sad, 0);
    chk("midrst best_cand", best_cand, 0);
    chk("midrst done", done, 0);
    for (int i = 0; i < 100; i++) @(negedge clk);
    pix_valid = 1'b0;
    chk("midrst no_done", done_cnt - dc0, 0);
    chk("midrst idle busy", busy, 0);

    run_vec(7, vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
